// File: rtl/alu_ctrl.sv
// alu_ctrl: sequences one ALU instruction at a time over a 4x16 register file.
// Optional ALU_CTRL_CARRY_CHAIN_EN feeds the stored CY into the ALU carry input.
// Ports: clk/rst_n (sync, active-low); req_* valid/ready instruction offer;
//   done/dout retirement pulse and result; flags {Z,CY,S,P,OV};
//   dbg_addr/dbg_data register peek; alu_* drive and return an external ALU.
module alu_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [1:0]  req_rd,
   input  logic [1:0]  req_rs,
   input  logic        req_imm_sel,
   input  logic [15:0] req_imm,
   input  logic        req_use_cy,
   output logic        done,
   output logic [15:0] dout,
   output logic [4:0]  flags,
   input  logic [1:0]  dbg_addr,
   output logic [15:0] dbg_data,
   output logic [2:0]  alu_opcode,
   output logic [15:0] alu_arg1,
   output logic [15:0] alu_arg2,
   output logic [4:0]  alu_in_flg,
   input  logic [15:0] alu_res,
   input  logic [4:0]  alu_out_flg
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t      state;
   logic [15:0] regs [4];
   logic [4:0]  flg_q;
   logic [15:0] dout_q;
   logic        ready_q;
   logic        done_q;
   logic [2:0]  op_q;
   logic [1:0]  rd_q;
   logic [1:0]  rs_q;
   logic        imm_sel_q;
   logic [15:0] imm_q;
   logic        exec;
   logic        cy_in;
   logic [15:0] arg2;

`ifdef ALU_CTRL_CARRY_CHAIN_EN
   logic        use_cy_q;
   assign cy_in = flg_q[3] & use_cy_q;
`else
   // Carry chain disabled: the request bit has no effect.
   logic        unused_use_cy;
   assign unused_use_cy = req_use_cy;
   assign cy_in = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
         flg_q     <= '0;
         dout_q    <= '0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         op_q      <= '0;
         rd_q      <= '0;
         rs_q      <= '0;
         imm_sel_q <= 1'b0;
         imm_q     <= '0;
`ifdef ALU_CTRL_CARRY_CHAIN_EN
         use_cy_q  <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req_valid && ready_q) begin
                  op_q      <= req_op;
                  rd_q      <= req_rd;
                  rs_q      <= req_rs;
                  imm_sel_q <= req_imm_sel;
                  imm_q     <= req_imm;
`ifdef ALU_CTRL_CARRY_CHAIN_EN
                  use_cy_q  <= req_use_cy;
`endif
                  ready_q   <= 1'b0;
                  state     <= S_EXEC;
               end
            end
            S_EXEC: begin
               regs[rd_q] <= alu_res;
               dout_q     <= alu_res;
               // MOV1/MOV2 leave the ALU carry undefined, so CY is kept.
               if (op_q[2:1] == 2'b11)
                  flg_q <= {alu_out_flg[4], flg_q[3], alu_out_flg[2:0]};
               else
                  flg_q <= alu_out_flg;
               done_q     <= 1'b1;
               state      <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   assign exec = (state == S_EXEC);
   // Both operands read the register file before this instruction's write.
   assign arg2 = imm_sel_q ? imm_q : regs[rs_q];

   assign alu_opcode = exec ? op_q : '0;
   assign alu_arg1   = exec ? regs[rd_q] : '0;
   assign alu_arg2   = exec ? arg2 : '0;
   assign alu_in_flg = exec ? {flg_q[4], cy_in, flg_q[2:0]} : '0;

   assign req_ready = ready_q;
   assign done      = done_q;
   assign dout      = dout_q;
   assign flags     = flg_q;
   assign dbg_data  = regs[dbg_addr];

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed checks of alu_ctrl against a small reference ALU.
// ALU flags: Z zero, CY carry/borrow, S sign, P odd parity, OV signed overflow.
module tb_alu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = '0;
   logic [1:0]  req_rd = '0;
   logic [1:0]  req_rs = '0;
   logic        req_imm_sel = 1'b0;
   logic [15:0] req_imm = '0;
   logic        req_use_cy = 1'b0;
   logic        done;
   logic [15:0] dout;
   logic [4:0]  flags;
   logic [1:0]  dbg_addr = '0;
   logic [15:0] dbg_data;
   logic [2:0]  alu_opcode;
   logic [15:0] alu_arg1;
   logic [15:0] alu_arg2;
   logic [4:0]  alu_in_flg;
   logic [15:0] alu_res;
   logic [4:0]  alu_out_flg;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   logic [2:0]  ex_op;
   logic [15:0] ex_a1;
   logic [15:0] ex_a2;
   logic [4:0]  ex_fl;
   logic [15:0] rv;

   alu_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_rd     (req_rd),
      .req_rs     (req_rs),
      .req_imm_sel(req_imm_sel),
      .req_imm    (req_imm),
      .req_use_cy (req_use_cy),
      .done       (done),
      .dout       (dout),
      .flags      (flags),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data),
      .alu_opcode (alu_opcode),
      .alu_arg1   (alu_arg1),
      .alu_arg2   (alu_arg2),
      .alu_in_flg (alu_in_flg),
      .alu_res    (alu_res),
      .alu_out_flg(alu_out_flg)
   );

   always #5 clk = ~clk;

   // Reference ALU; carry reported as 0 for logic ops and moves.
   logic [16:0] aw;
   logic        aov;
   always_comb begin
      aw  = '0;
      aov = 1'b0;
      case (alu_opcode)
         3'd0: begin
            aw  = {1'b0, alu_arg1} + {1'b0, alu_arg2} + {16'b0, alu_in_flg[3]};
            aov = (alu_arg1[15] == alu_arg2[15]) && (aw[15] != alu_arg1[15]);
         end
         3'd1: begin
            aw  = {1'b0, alu_arg1} - {1'b0, alu_arg2} - {16'b0, alu_in_flg[3]};
            aov = (alu_arg1[15] != alu_arg2[15]) && (aw[15] != alu_arg1[15]);
         end
         3'd2: aw = {1'b0, alu_arg1 & alu_arg2};
         3'd3: aw = {1'b0, alu_arg1 | alu_arg2};
         3'd4: aw = {1'b0, alu_arg1 ^ alu_arg2};
         3'd5: aw = {1'b0, ~alu_arg1};
         3'd6: aw = {1'b0, alu_arg1};
         default: aw = {1'b0, alu_arg2};
      endcase
   end
   assign alu_res     = aw[15:0];
   assign alu_out_flg = {(aw[15:0] == 16'h0), aw[16], aw[15], ^aw[15:0], aov};

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [15:0] v);
      dbg_addr = a;
      #1;
      v = dbg_data;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Offer one instruction, scramble req_* after acceptance, wait for done.
   task automatic run(input logic [2:0] op, input logic [1:0] rd,
                      input logic [1:0] rs, input logic sel,
                      input logic [15:0] imm, input logic cy);
      int lat;
      @(negedge clk);
      req_op = op; req_rd = rd; req_rs = rs;
      req_imm_sel = sel; req_imm = imm; req_use_cy = cy;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      req_op = ~op; req_rd = ~rd; req_rs = ~rs;
      req_imm_sel = ~sel; req_imm = ~imm; req_use_cy = ~cy;
      ex_op = alu_opcode; ex_a1 = alu_arg1;
      ex_a2 = alu_arg2; ex_fl = alu_in_flg;
      lat = 1;
      while (done !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 16'(lat), 16'd2);
   endtask

   logic [6:0]  rdy_pat;
   logic [6:0]  done_pat;
   int          ndone;
   logic [15:0] r1;
   logic [15:0] r2;
   logic        saw_done;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_ready", 16'(req_ready), 16'd1);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_dout", dout, 16'h0000);
      chk("rst_flags", 16'(flags), 16'h0000);
      chk("idle_alu_op", 16'(alu_opcode), 16'h0);
      chk("idle_in_flg", 16'(alu_in_flg), 16'h0);
      rd_reg(2'd3, rv);
      chk("rst_r3", rv, 16'h0000);

      // MOV2 R1, #0x00FF
      run(3'd7, 2'd1, 2'd0, 1'b1, 16'h00FF, 1'b0);
      chk("mov2_dout", dout, 16'h00FF);
      chk("mov2_ex_op", 16'(ex_op), 16'h7);
      chk("mov2_ex_a2", ex_a2, 16'h00FF);
      chk("mov2_flags", 16'(flags), 16'h00);
      rd_reg(2'd1, rv);
      chk("mov2_r1", rv, 16'h00FF);

      // R0=FFFF, R1=0001, ADD R0,R1
      run(3'd7, 2'd0, 2'd0, 1'b1, 16'hFFFF, 1'b0);
      chk("movffff_flags", 16'(flags), 16'h04);
      run(3'd7, 2'd1, 2'd0, 1'b1, 16'h0001, 1'b0);
      chk("mov1_flags", 16'(flags), 16'h02);
      run(3'd0, 2'd0, 2'd1, 1'b0, 16'h0000, 1'b0);
      chk("add_ex_a1", ex_a1, 16'hFFFF);
      chk("add_ex_a2", ex_a2, 16'h0001);
      chk("add_dout", dout, 16'h0000);
      chk("add_flags", 16'(flags), 16'h18);
      rd_reg(2'd0, rv);
      chk("add_r0", rv, 16'h0000);

      // ADD R2, #0 with carry in
      run(3'd0, 2'd2, 2'd0, 1'b1, 16'h0000, 1'b1);
      rd_reg(2'd2, rv);
`ifdef ALU_CTRL_CARRY_CHAIN_EN
      chk("adc_in_flg", 16'(ex_fl), 16'h18);
      chk("adc_r2", rv, 16'h0001);
      chk("adc_flags", 16'(flags), 16'h02);
`else
      chk("adc_in_flg", 16'(ex_fl), 16'h10);
      chk("adc_r2", rv, 16'h0000);
      chk("adc_flags", 16'(flags), 16'h10);
`endif

      // CY retention across moves: 0x8000+0x8000 via rd==rs
      run(3'd7, 2'd3, 2'd0, 1'b1, 16'h8000, 1'b0);
      run(3'd0, 2'd3, 2'd3, 1'b0, 16'h0000, 1'b0);
      chk("rdrs_a1", ex_a1, 16'h8000);
      chk("rdrs_a2", ex_a2, 16'h8000);
      chk("rdrs_flags", 16'(flags), 16'h19);
      run(3'd7, 2'd3, 2'd0, 1'b1, 16'h1234, 1'b0);
      chk("mov2cy_flags", 16'(flags), 16'h0A);
      run(3'd6, 2'd3, 2'd0, 1'b0, 16'h0000, 1'b0);
      chk("mov1cy_dout", dout, 16'h1234);
      chk("mov1cy_flags", 16'(flags), 16'h0A);
      run(3'd4, 2'd3, 2'd3, 1'b0, 16'h0000, 1'b0);
      rd_reg(2'd3, rv);
      chk("xor_r3", rv, 16'h0000);
      chk("xor_flags", 16'(flags), 16'h10);

      // req_valid held 6 cycles: SUB R0, #1 twice
      @(negedge clk);
      req_op = 3'd1; req_rd = 2'd0; req_rs = 2'd0;
      req_imm_sel = 1'b1; req_imm = 16'h0001; req_use_cy = 1'b0;
      req_valid = 1'b1;
      rdy_pat = '0; done_pat = '0; ndone = 0; r1 = '0; r2 = '0;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 6) req_valid = 1'b0;
         rdy_pat[6-i]  = req_ready;
         done_pat[6-i] = done;
         if (done === 1'b1) begin
            if (ndone == 0) r1 = dout;
            else r2 = dout;
            ndone++;
         end
      end
      repeat (4) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      chk("hold_ready_pat", 16'(rdy_pat), 16'h0049);
      chk("hold_done_pat", 16'(done_pat), 16'h0012);
      chk("hold_retires", 16'(ndone), 16'd2);
      chk("sub1_res", r1, 16'hFFFF);
      chk("sub2_res", r2, 16'hFFFE);
      chk("sub_flags", 16'(flags), 16'h06);
      chk("dout_hold", dout, 16'hFFFE);

      // Reset during EXEC of ADD R1, #5
      do_reset();
      @(negedge clk);
      req_op = 3'd0; req_rd = 2'd1; req_rs = 2'd0;
      req_imm_sel = 1'b1; req_imm = 16'h0005; req_use_cy = 1'b0;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstex_a2", alu_arg2, 16'h0005);
      rst_n = 1'b0;
      saw_done = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         if (done === 1'b1) saw_done = 1'b1;
         @(negedge clk);
      end
      chk("rstex_no_done", 16'(saw_done), 16'd0);
      chk("rstex_flags", 16'(flags), 16'h00);
      rd_reg(2'd1, rv);
      chk("rstex_r1", rv, 16'h0000);

      // Reset during DONE drops done next cycle
      run(3'd7, 2'd2, 2'd0, 1'b1, 16'hABCD, 1'b0);
      chk("rstdn_done_hi", 16'(done), 16'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstdn_done_lo", 16'(done), 16'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstdn_ready", 16'(req_ready), 16'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
